geofence_poly: RTL and testbench
================================

# geofence_poly

Parametrised successor to the fixed six-vertex geofence checker. Accepts one target point and `N_VERT` fence vertices in arbitrary order over a valid-qualified stream. Sorts the vertices into a consistent winding order by cross-product selection. Classifies the target as strictly inside, on the boundary, or outside, and reports the result with a one-cycle `valid` strobe. One shared cross-product datapath serves both the sort and the test phases.

## Interface

- `N_VERT`, default 6: number of polygon vertices. Legal range 3..8.
- `CW`, default 10: unsigned coordinate width.
- `clk` input 1: clock. All state changes on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: beat qualifier for `X`/`Y`.
- `in_ready` output 1: high only in `S_INPUT`. A beat is accepted when `in_valid && in_ready`.
- `X` input CW: unsigned x coordinate.
- `Y` input CW: unsigned y coordinate.
- `valid` output 1: result strobe, high for exactly one cycle.
- `is_inside` output 1: target strictly inside. Meaningful only with `valid`, otherwise 0.
- `is_on_edge` output 1: target on an edge or vertex. Meaningful only with `valid`, otherwise 0.

## Operation

- **Frame format:** beat 0 is the target; beats 1..`N_VERT` are vertices V0..V(N-1).
- **Input constraints:** no three vertices collinear; the polygon is convex.
- **States:** `S_INPUT` → `S_SORT` → `S_TEST` → `S_RESULT` → `S_INPUT`.
- **`S_INPUT`:**
  - The beat counter advances only on accepted beats. Gaps in `in_valid` stall the frame with no timeout.
  - Leaves for `S_SORT` in the cycle after beat `N_VERT` is accepted.
- **`S_SORT`:**
  - Pair indices (i,j) run i = 1..N-2, j = i+1..N-1, lexicographic order, one pair per cycle.
  - Compute c = (Vi−V0)×(Vj−V0) = dxi·dyj − dyi·dxj.
  - If c ≥ 0, swap Vi and Vj.
  - Runs P = (N−1)(N−2)/2 cycles; after the last pair, go to `S_TEST`.
  - Post-condition: c < 0 for every i < j.
- **`S_TEST`:**
  - k = 0..N-1, one edge per cycle.
  - e_k = (Vk−T)×(V((k+1) mod N)−Vk).
  - Sticky flags `any_pos` (e_k > 0) and `any_zero` (e_k = 0), both cleared on entry to `S_TEST`.
  - After k = N-1, go to `S_RESULT`.
- **`S_RESULT`:**
  - `valid` = 1.
  - `is_inside` = !`any_pos` && !`any_zero`.
  - `is_on_edge` = !`any_pos` && `any_zero`.
  - Both 0 means outside. They are never both 1.
- **Arithmetic:**
  - Coordinates are zero-extended to CW+2 signed bits; differences are CW+2 signed.
  - Products and cross results are PW = 2·CW+5 signed bits, so there is no overflow.
- **Ignored input:** `in_valid` is ignored outside `S_INPUT`. `X`/`Y` are don't-care then.
- **Reset:** asserting `reset` low at any time (mid-frame, mid-sort, mid-test):
  - immediately forces `S_INPUT` and zeroes the beat counter, indices and flags;
  - forces `valid`, `is_inside` and `is_on_edge` to 0;
  - sets `in_ready` to 1.
  - Vertex and target registers are cleared to 0.
  - The first accepted beat after release is the target.

## Timing

- **Reset values:** `valid`=0, `is_inside`=0, `is_on_edge`=0, `in_ready`=1.
- **Latency:** with the last vertex accepted at edge t, the FSM is in:
  - `S_SORT` during cycles t+1..t+P;
  - `S_TEST` during cycles t+P+1..t+P+N;
  - `S_RESULT` during cycle t+P+N+1, when `valid` is high.
  - For N=6: P=10, so `valid` is high in cycle t+17.
- **Minimum frame period:** (N+1) + P + N + 1 cycles (N=6: 24). `in_ready` rises again in the cycle after `S_RESULT`.
- **Output registering:** outputs are registered or decoded from registered state only. There is no combinational path from `X`/`Y`/`in_valid` to any output.

## Structure

- **`geofence_pkg`:**
  - state enum (`S_INPUT`, `S_SORT`, `S_TEST`, `S_RESULT`);
  - function `pw(CW)` returning 2·CW+5;
  - localparam for index width, $clog2(8)=3.
- **Sub-module `geofence_cross`:**
  - combinational signed cross product `ax·by − ay·bx`, parametrised on input width;
  - exactly one instance, operands muxed by state.
- **Top module:** FSM, counters, vertex register file with swap port, sticky flags.

## Test plan

- **Inside, default params:** hexagon (600,500),(450,413),(550,587),(400,500),(550,413),(450,587) shuffled, target (500,500) → `valid` in cycle t+17, `is_inside`=1, `is_on_edge`=0.
- **Outside:** same hexagon, target (700,500) → `is_inside`=0, `is_on_edge`=0.
- **Square, N_VERT=4:** vertices (300,300),(100,100),(100,300),(300,100):
  - target (200,100) → `is_on_edge`=1, `is_inside`=0;
  - target (200,200) → `is_inside`=1;
  - target (300,300) (vertex) → `is_on_edge`=1;
  - `valid` at t+3+4+1 = t+8.
- **Stalls:** hexagon frame with `in_valid` low for 3 cycles between every beat → identical result to the unstalled frame; `in_ready` stays high throughout input.
- **Reset mid-sort:** `reset` low for one cycle during `S_SORT`:
  - immediately `valid`=0 and `in_ready`=1;
  - the next full frame (target (500,500)) gives `is_inside`=1 with no residue from the aborted frame.
- **Back-to-back frames:** target beat presented in the cycle after `S_RESULT` → accepted; the second result is correct and independent of the first.

Source files
------------

// File: rtl/geofence_pkg.sv
// Shared types and sizing helpers for the polygon geofence checker.
package geofence_pkg;

    typedef enum logic [1:0] {
        S_INPUT  = 2'd0,
        S_SORT   = 2'd1,
        S_TEST   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam int MAX_VERT = 8;
    localparam int IW       = $clog2(MAX_VERT);

    // Cross-product width that can never overflow for CW-bit unsigned coordinates.
    function automatic int pw(input int cw);
        return 2 * cw + 5;
    endfunction

endpackage

// File: rtl/geofence_cross.sv
// Combinational signed 2-D cross product ax*by - ay*bx, one bit wider than the products.
module geofence_cross #(
    parameter int AW = 12
) (
    input  logic signed [AW-1:0] ax,
    input  logic signed [AW-1:0] ay,
    input  logic signed [AW-1:0] bx,
    input  logic signed [AW-1:0] by,
    output logic signed [2*AW:0] c
);

    logic [2*AW-1:0] p0_s;
    logic [2*AW-1:0] p1_s;

    // Sign-extended operands make the truncated unsigned product equal the signed product.
    assign p0_s = {{AW{ax[AW-1]}}, ax} * {{AW{by[AW-1]}}, by};
    assign p1_s = {{AW{ay[AW-1]}}, ay} * {{AW{bx[AW-1]}}, bx};
    assign c    = {p0_s[2*AW-1], p0_s} - {p1_s[2*AW-1], p1_s};

endmodule

// File: rtl/geofence_poly.sv
// Convex-polygon geofence: loads a target and N_VERT vertices, sorts them into
// clockwise order, then classifies the target as inside, on an edge, or outside.
module geofence_poly
    import geofence_pkg::*;
#(
    parameter int N_VERT = 6,
    parameter int CW     = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    output logic          valid,
    output logic          is_inside,
    output logic          is_on_edge
);

    localparam int DW = CW + 2;
    localparam int PW = pw(CW);
    localparam logic [3:0]    LAST_BEAT = 4'(N_VERT);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_VERT - 1);
    localparam logic [IW-1:0] LAST_I    = IW'(N_VERT - 2);

    state_t               state_q, state_d;
    logic [3:0]           beat_q, beat_d;
    logic [IW-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
    logic [CW-1:0]        vx_q [MAX_VERT];
    logic [CW-1:0]        vy_q [MAX_VERT];
    logic [CW-1:0]        vx_d [MAX_VERT];
    logic [CW-1:0]        vy_d [MAX_VERT];
    logic [CW-1:0]        tx_q, tx_d, ty_q, ty_d;
    logic                 any_pos_q, any_pos_d, any_zero_q, any_zero_d;
    logic                 valid_q, valid_d, inside_q, inside_d, edge_q, edge_d;
    logic signed [DW-1:0] ax_s, ay_s, bx_s, by_s;
    logic signed [PW-1:0] cross_s;
    logic [IW-1:0]        kn_s, beat_idx_s;
    logic                 pos_s, zero_s;

    function automatic logic signed [DW-1:0] diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return $signed({2'b00, a}) - $signed({2'b00, b});
    endfunction

    assign kn_s       = (k_q == LAST_IDX) ? '0 : k_q + IW'(1);
    assign beat_idx_s = beat_q[IW-1:0] - IW'(1);
    assign zero_s     = (cross_s == '0);
    assign pos_s      = !cross_s[PW-1] && !zero_s;

    // Operand mux for the single shared cross-product unit.
    always_comb begin
        ax_s = '0;
        ay_s = '0;
        bx_s = '0;
        by_s = '0;
        case (state_q)
            S_SORT: begin
                ax_s = diff(vx_q[i_q], vx_q[0]);
                ay_s = diff(vy_q[i_q], vy_q[0]);
                bx_s = diff(vx_q[j_q], vx_q[0]);
                by_s = diff(vy_q[j_q], vy_q[0]);
            end
            S_TEST: begin
                ax_s = diff(vx_q[k_q], tx_q);
                ay_s = diff(vy_q[k_q], ty_q);
                bx_s = diff(vx_q[kn_s], vx_q[k_q]);
                by_s = diff(vy_q[kn_s], vy_q[k_q]);
            end
            default: begin
                ax_s = '0;
            end
        endcase
    end

    geofence_cross #(.AW(DW)) u_cross (
        .ax (ax_s),
        .ay (ay_s),
        .bx (bx_s),
        .by (by_s),
        .c  (cross_s)
    );

    // Next-state logic: frame capture, pairwise sort, edge test, result strobe.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        any_pos_d  = any_pos_q;
        any_zero_d = any_zero_q;
        valid_d    = 1'b0;
        inside_d   = 1'b0;
        edge_d     = 1'b0;
        case (state_q)
            S_INPUT: begin
                if (in_valid) begin
                    if (beat_q == 4'd0) begin
                        tx_d = X;
                        ty_d = Y;
                    end else begin
                        vx_d[beat_idx_s] = X;
                        vy_d[beat_idx_s] = Y;
                    end
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = 4'd0;
                        state_d = S_SORT;
                        i_d     = IW'(1);
                        j_d     = IW'(2);
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            S_SORT: begin
                // Non-negative cross means Vj is not clockwise of Vi around V0.
                if (!cross_s[PW-1]) begin
                    vx_d[i_q] = vx_q[j_q];
                    vx_d[j_q] = vx_q[i_q];
                    vy_d[i_q] = vy_q[j_q];
                    vy_d[j_q] = vy_q[i_q];
                end else begin
                    vx_d = vx_q;
                end
                if (j_q == LAST_IDX) begin
                    if (i_q == LAST_I) begin
                        state_d    = S_TEST;
                        k_d        = '0;
                        any_pos_d  = 1'b0;
                        any_zero_d = 1'b0;
                    end else begin
                        i_d = i_q + IW'(1);
                        j_d = i_q + IW'(2);
                    end
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            S_TEST: begin
                any_pos_d  = any_pos_q | pos_s;
                any_zero_d = any_zero_q | zero_s;
                if (k_q == LAST_IDX) begin
                    state_d  = S_RESULT;
                    k_d      = '0;
                    valid_d  = 1'b1;
                    inside_d = !any_pos_d && !any_zero_d;
                    edge_d   = !any_pos_d && any_zero_d;
                end else begin
                    k_d = kn_s;
                end
            end
            S_RESULT: begin
                state_d = S_INPUT;
            end
            default: begin
                state_d = S_INPUT;
            end
        endcase
    end

    // State, vertex file and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_INPUT;
            beat_q     <= 4'd0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            any_pos_q  <= 1'b0;
            any_zero_q <= 1'b0;
            valid_q    <= 1'b0;
            inside_q   <= 1'b0;
            edge_q     <= 1'b0;
            for (int n = 0; n < MAX_VERT; n++) begin
                vx_q[n] <= '0;
                vy_q[n] <= '0;
            end
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            any_pos_q  <= any_pos_d;
            any_zero_q <= any_zero_d;
            valid_q    <= valid_d;
            inside_q   <= inside_d;
            edge_q     <= edge_d;
            for (int n = 0; n < MAX_VERT; n++) begin
                vx_q[n] <= vx_d[n];
                vy_q[n] <= vy_d[n];
            end
        end
    end

    assign in_ready   = (state_q == S_INPUT);
    assign valid      = valid_q;
    assign is_inside  = inside_q;
    assign is_on_edge = edge_q;

endmodule

// File: tb/tb_geofence_poly.sv
// Directed bench: a hexagon instance (N_VERT=6) and a square instance (N_VERT=4)
// driven from a vector table plus reset-mid-sort and back-to-back sequences.
module tb_geofence_poly;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       sel = 1'b0;
    logic [9:0] X = 10'd0;
    logic [9:0] Y = 10'd0;

    logic ready6, valid6, ins6, edge6;
    logic ready4, valid4, ins4, edge4;
    logic in_valid6, in_valid4;
    logic ready_m, valid_m, ins_m, edge_m;

    int checks = 0;
    int errors = 0;

    int hex_x [6] = '{600, 450, 550, 400, 550, 450};
    int hex_y [6] = '{500, 413, 587, 500, 413, 587};
    int sq_x  [4] = '{300, 100, 100, 300};
    int sq_y  [4] = '{300, 100, 300, 100};

    typedef struct packed {
        logic       sq;
        logic [9:0] tx;
        logic [9:0] ty;
        logic [1:0] stall;
        logic       exp_in;
        logic       exp_edge;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    assign in_valid6 = in_valid & ~sel;
    assign in_valid4 = in_valid & sel;
    assign ready_m   = sel ? ready4 : ready6;
    assign valid_m   = sel ? valid4 : valid6;
    assign ins_m     = sel ? ins4   : ins6;
    assign edge_m    = sel ? edge4  : edge6;

    geofence_poly dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid6), .in_ready(ready6),
        .X(X), .Y(Y), .valid(valid6), .is_inside(ins6), .is_on_edge(edge6)
    );

    geofence_poly #(.N_VERT(4), .CW(10)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(ready4),
        .X(X), .Y(Y), .valid(valid4), .is_inside(ins4), .is_on_edge(edge4)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Sends target + vertices; returns #1 after the edge accepting the last vertex.
    task automatic send_frame(input bit sq, input int tx, input int ty, input int stall,
                              output int tries0);
        int n;
        int tries;
        n = sq ? 4 : 6;
        tries0 = 0;
        for (int b = 0; b <= n; b++) begin
            if (b > 0) begin
                for (int s = 0; s < stall; s++) begin
                    in_valid = 1'b0;
                    chk("ready_during_stall", ready_m, 1);
                    @(negedge clk);
                end
            end
            if (b == 0) begin
                X = 10'(tx); Y = 10'(ty);
            end else if (sq) begin
                X = 10'(sq_x[b-1]); Y = 10'(sq_y[b-1]);
            end else begin
                X = 10'(hex_x[b-1]); Y = 10'(hex_y[b-1]);
            end
            in_valid = 1'b1;
            tries = 0;
            while (ready_m !== 1'b1 && tries < 50) begin
                @(negedge clk);
                tries++;
            end
            if (tries >= 50) chk("accept_timeout", 0, 1);
            if (b == 0) tries0 = tries;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (b < n) @(negedge clk);
        end
    endtask

    // Counts cycles after the last-vertex edge until valid; ends on that negedge.
    task automatic wait_result(input string nm, input int exp_lat, input int exp_in,
                               input int exp_edge);
        int n;
        bit got;
        bit quiet;
        n = 0;
        got = 1'b0;
        quiet = 1'b1;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (valid_m) got = 1'b1;
            else if (ins_m || edge_m) quiet = 1'b0;
        end
        chk({nm, "_valid_seen"}, got, 1);
        if (got) begin
            chk({nm, "_latency"}, n, exp_lat);
            chk({nm, "_is_inside"}, ins_m, exp_in);
            chk({nm, "_is_on_edge"}, edge_m, exp_edge);
            chk({nm, "_quiet_before_valid"}, quiet, 1);
        end
    endtask

    task automatic post_check(input string nm);
        @(negedge clk);
        chk({nm, "_valid_one_cycle"}, valid_m, 0);
        chk({nm, "_flags_cleared"}, {31'd0, ins_m | edge_m}, 0);
        chk({nm, "_ready_back"}, ready_m, 1);
    endtask

    initial begin
        int t0;
        vecs[0] = '{1'b0, 10'd500, 10'd500, 2'd0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 10'd700, 10'd500, 2'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 10'd200, 10'd100, 2'd0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 10'd200, 10'd200, 2'd0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 10'd300, 10'd300, 2'd0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 10'd500, 10'd500, 2'd3, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 10'd600, 10'd500, 2'd0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 10'd50,  10'd200, 2'd0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 10'd500, 10'd413, 2'd0, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 10'd0,   10'd0,   2'd1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_valid6", valid6, 0);
        chk("reset_flags6", {30'd0, ins6, edge6}, 0);
        chk("reset_ready6", ready6, 1);
        chk("reset_ready4", ready4, 1);
        chk("reset_valid4", valid4, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            sel = vecs[v].sq;
            send_frame(vecs[v].sq, int'(vecs[v].tx), int'(vecs[v].ty), int'(vecs[v].stall), t0);
            wait_result($sformatf("vec%0d", v), vecs[v].sq ? 8 : 17,
                        int'(vecs[v].exp_in), int'(vecs[v].exp_edge));
            post_check($sformatf("vec%0d", v));
        end

        // Abort an outside frame during the sort, then run a clean inside frame.
        sel = 1'b0;
        send_frame(1'b0, 700, 500, 0, t0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midsort_reset_valid", valid6, 0);
        chk("midsort_reset_ready", ready6, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_frame(1'b0, 500, 500, 0, t0);
        wait_result("after_reset", 17, 1, 0);
        post_check("after_reset");

        // Back-to-back: next target offered while the result is on the outputs.
        send_frame(1'b0, 700, 500, 0, t0);
        wait_result("b2b_first", 17, 0, 0);
        send_frame(1'b0, 500, 500, 0, t0);
        chk("b2b_target_wait", t0, 1);
        wait_result("b2b_second", 17, 1, 0);
        post_check("b2b_second");

        sel = 1'b1;
        send_frame(1'b1, 200, 200, 0, t0);
        wait_result("sq_b2b_first", 8, 1, 0);
        send_frame(1'b1, 100, 200, 0, t0);
        chk("sq_b2b_target_wait", t0, 1);
        wait_result("sq_b2b_second", 8, 0, 1);
        post_check("sq_b2b_second");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
